// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for the EX stage: one iteration per clock,
// with a stall request to the pipeline while busy and a {remainder, quotient} result.
module div_sequencer #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           annul_i,
  input  logic           signed_i,
  input  logic [W-1:0]   dividend_i,
  input  logic [W-1:0]   divisor_i,
  output logic [2*W-1:0] result_o,
  output logic           ready_o,
  output logic           stallreq_o
);

  typedef enum logic [2:0] {IDLE, BYZERO, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W:0]       prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   result_q, result_d;
  logic             ready_q, ready_d;

  logic [W-1:0] dvd_mag, dvs_mag, quot_fix, rem_fix;
  logic [W:0]   shifted;
  logic         fits, last_iter, launch;

  assign launch    = start_i && !annul_i;
  assign dvd_mag   = (signed_i && dividend_i[W-1]) ? -dividend_i : dividend_i;
  assign dvs_mag   = (signed_i && divisor_i[W-1])  ? -divisor_i  : divisor_i;
  // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder.
  assign shifted   = {prem_q[W-1:0], quot_q[W-1]};
  assign fits      = shifted >= {1'b0, dvs_q};
  assign last_iter = (cnt_q == CNT_W'(W-1));
  assign quot_fix  = (sgn_q && (neg_dvd_q ^ neg_dvs_q)) ? -quot_q : quot_q;
  assign rem_fix   = (sgn_q && neg_dvd_q) ? -prem_q[W-1:0] : prem_q[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      dvs_q     <= '0;
      quot_q    <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      dvs_q     <= dvs_d;
      quot_q    <= quot_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = (divisor_i == '0) ? BYZERO : RUN;
      BYZERO:  state_d = annul_i ? IDLE : DONE;
      RUN:     if (annul_i) state_d = IDLE;
               else if (last_iter) state_d = FIX;
      FIX:     state_d = annul_i ? IDLE : DONE;
      DONE:    if (!start_i || annul_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sgn_d     = sgn_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    dvs_d     = dvs_q;
    quot_d    = quot_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (launch) begin
          sgn_d     = signed_i;
          neg_dvd_d = dividend_i[W-1];
          neg_dvs_d = divisor_i[W-1];
          dvs_d     = dvs_mag;
          quot_d    = dvd_mag;
          prem_d    = '0;
          cnt_d     = '0;
        end
      end
      RUN: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          prem_d = fits ? (shifted - {1'b0, dvs_q}) : shifted;
          quot_d = {quot_q[W-2:0], fits};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      BYZERO: begin
        result_d = '0;
        ready_d  = !annul_i;
      end
      FIX: begin
        result_d = annul_i ? '0 : {rem_fix, quot_fix};
        ready_d  = !annul_i;
      end
      DONE: begin
        if (!start_i || annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i && !ready_q && !annul_i;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_i;
  logic [31:0] dividend_i, divisor_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int num_cmp = 0;
  int num_mis = 0;

  div_sequencer #(.W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_cmp++;
    if (obs !== exp) begin
      num_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Truncating division; remainder takes the dividend's sign; x/0 gives 0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // drop_at > 0 releases start_i that many cycles into the run; the divide must still finish.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit toggle, input int drop_at);
    logic [63:0] exp;
    int lat, n, stalls;
    bit got;
    exp = ref_div(s, a, b);
    lat = (b == 32'd0) ? 2 : 34;
    stalls = 0;
    got = 1'b0;
    n = 0;
    @(negedge clk);
    signed_i = s; dividend_i = a; divisor_i = b; start_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      #1;
      if (stallreq_o) stalls++;
      @(negedge clk);
      n = i;
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      if (toggle) begin
        dividend_i = $urandom; divisor_i = $urandom; signed_i = ~signed_i;
      end
      if (drop_at == i) start_i = 1'b0;
    end
    check("latency", 64'(got ? n : 999), 64'(lat));
    check("result", result_o, exp);
    if (drop_at == 0) begin
      check("stall_cycles", 64'(stalls), 64'(lat));
      check("stall_low_at_ready", 64'(stallreq_o), 64'd0);
    end
    $display("div s=%0b a=%h b=%h -> %h (exp %h) lat=%0d", s, a, b, result_o, exp, n);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("release_ready", 64'(ready_o), 64'd0);
    check("release_result", result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0, 1'b0, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, 0);
    run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, 1'b0, 0);
    run_div(1'b0, 32'h0000_1234, 32'h0000_0000, 0, 1'b0, 0);

    // Annul at iteration 10, then make sure nothing completes.
    @(negedge clk);
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    begin
      int rises = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ready_o) rises++;
      end
      check("annul_no_ready", 64'(rises), 64'd0);
    end
    $display("annul at iteration 10 done");
    run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0, 1'b0, 0);

    // Reset during iteration 20.
    @(negedge clk);
    signed_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'd7; start_i = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    $display("reset at iteration 20 done");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 0);

    run_div(1'b0, 32'd1234567, 32'd89, 5, 1'b1, 0);
    run_div(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 0, 1'b0, 5);
    run_div(1'b1, 32'h0000_0000, 32'hFFFF_FFFD, 0, 1'b0, 0);
    run_div(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, $urandom_range(0, 2), 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_mis);
    $finish;
  end

endmodule
